// File: rtl/interleaver_ctrl.sv
// interleaver_ctrl: ping-pong bank controller producing interleaved write and linear read addresses.
module interleaver_ctrl #(
  parameter int MAX_CBPS = 288,
  parameter int AW = 9
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    Rate,
  input  logic [11:0]   NumSymbols,
  input  logic          InValid,
  output logic          InReady,
  output logic          WrEn,
  output logic          WrBank,
  output logic [AW-1:0] WrAddr,
  input  logic          RdReady,
  output logic          RdEn,
  output logic          RdBank,
  output logic [AW-1:0] RdAddr,
  output logic          RdLast,
  output logic          Busy,
  output logic          Done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [11:0] num_syms, wr_syms, rd_syms;
  logic [1:0] full, full_set, full_clr;
  logic [1:0] bank_rate [2];
  logic [1:0] wr_rate, s_w, cmod, rmod, dmod;
  logic [AW-1:0] k, base, rd_cnt, nrows;
  logic [4:0] row;
  logic [3:0] col;
  logic wr_last, start_go, fin, done_r, done_nx;
  // 64QAM fills a whole bank
  function automatic logic [AW-1:0] ncbps(input logic [1:0] r);
    return r == 2'd0 ? AW'(48) : r == 2'd1 ? AW'(96) : r == 2'd2 ? AW'(192) : AW'(MAX_CBPS);
  endfunction
  // rate is taken live on k=0 because the bank register only captures it on that write
  always_comb begin
    wr_rate  = k == '0 ? Rate : bank_rate[WrBank];
    s_w      = wr_rate == 2'd3 ? 2'd3 : wr_rate == 2'd2 ? 2'd2 : 2'd1;
    nrows    = ncbps(wr_rate) >> 4;
    start_go = state == IDLE && Start && NumSymbols != '0;
    InReady  = state == RUN && !full[WrBank] && wr_syms != num_syms;
    WrEn     = InValid && InReady;
    wr_last  = WrEn && k == ncbps(wr_rate) - AW'(1);
    dmod     = rmod >= cmod ? rmod - cmod : 2'(3'(rmod) + 3'(s_w) - 3'(cmod));
    WrAddr   = base + AW'(row) - AW'(rmod) + AW'(dmod);
    RdEn     = state != IDLE && full[RdBank] && RdReady;
    RdAddr   = rd_cnt;
    RdLast   = RdEn && rd_cnt == ncbps(bank_rate[RdBank]) - AW'(1);
    full_set = wr_last ? 2'b01 << WrBank : 2'b00;
    full_clr = RdLast ? 2'b01 << RdBank : 2'b00;
    fin      = state == DRAIN && RdLast && rd_syms == num_syms - 12'd1;
    done_nx  = fin || (state == IDLE && Start && NumSymbols == '0);
    Busy     = state != IDLE;
    Done     = done_r;
    state_nx = start_go ? RUN :
               state == RUN && wr_last && wr_syms == num_syms - 12'd1 ? DRAIN :
               fin ? IDLE : state;
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state  <= IDLE;
      done_r <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= done_nx;
    end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      {num_syms, wr_syms, rd_syms, full, WrBank, RdBank} <= '0;
      {k, base, rd_cnt, row, col, cmod, rmod} <= '0;
      bank_rate[0] <= '0;
      bank_rate[1] <= '0;
    end else if (start_go) begin
      {wr_syms, rd_syms, full, WrBank, RdBank} <= '0;
      {k, base, rd_cnt, row, col, cmod, rmod} <= '0;
      bank_rate[0] <= '0;
      bank_rate[1] <= '0;
      num_syms <= NumSymbols;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (WrEn) begin
        if (k == '0) bank_rate[WrBank] <= Rate;
        if (wr_last) begin
          {k, base, row, col, cmod, rmod} <= '0;
          WrBank  <= ~WrBank;
          wr_syms <= wr_syms + 12'd1;
        end else begin
          k <= k + AW'(1);
          if (col == 4'd15) begin
            {col, base, cmod} <= '0;
            row  <= row + 5'd1;
            rmod <= rmod == s_w - 2'd1 ? 2'd0 : rmod + 2'd1;
          end else begin
            col  <= col + 4'd1;
            base <= base + nrows;
            cmod <= cmod == s_w - 2'd1 ? 2'd0 : cmod + 2'd1;
          end
        end
      end
      if (RdLast) begin
        rd_cnt  <= '0;
        RdBank  <= ~RdBank;
        rd_syms <= rd_syms + 12'd1;
      end else if (RdEn) rd_cnt <= rd_cnt + AW'(1);
    end
endmodule

// File: doc/interleaver_ctrl.md
INTERLEAVER_CTRL -- requirements
Module: interleaver_ctrl

Interface
REQ-001 SHALL have parameter MAX_CBPS, default 288, meaning the largest coded-bits-per-symbol count a memory bank holds.
REQ-002 SHALL have parameter AW, default 9, meaning the memory address width (2^AW >= MAX_CBPS).
REQ-003 SHALL have ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  begin frame (pulse)
- Rate  in  2  modulation: 0=BPSK N_CBPS=48 s=1, 1=QPSK 96 s=1, 2=16QAM 192 s=2, 3=64QAM 288 s=3
- NumSymbols  in  12  OFDM symbols in the frame
- InValid  in  1  coded bit available
- InReady  out  1  controller accepts a bit
- WrEn  out  1  write strobe to the bank memory
- WrBank  out  1  bank being written
- WrAddr  out  AW  interleaved write address
- RdReady  in  1  downstream accepts a read
- RdEn  out  1  read strobe
- RdBank  out  1  bank being read
- RdAddr  out  AW  linear read address
- RdLast  out  1  marks the last read of a symbol
- Busy  out  1  frame in progress
- Done  out  1  one-cycle pulse when the frame has been fully read

Function
REQ-004 SHALL operate in states IDLE, RUN and DRAIN.
REQ-005 SHALL treat a write as the cycle where InValid&InReady; write handling:
- WrEn = InValid&InReady, combinational from registered state.
- InReady=1 iff state=RUN, bank WrBank is not full, and not all NumSymbols symbols have been written.
REQ-006 SHALL latch Rate into the per-bank rate register of WrBank on the first write (k=0) of each symbol; Rate changes mid-symbol have no effect.
REQ-007 SHALL, for input bit index k (0..N_CBPS-1) of a symbol, drive WrAddr=j as follows:
- N_ROWS=N_CBPS/16, col=k mod 16, row=floor(k/16).
- i=N_ROWS*col+row.
- j=s*floor(i/s)+((i-col) mod s).
REQ-008 SHALL generate WrAddr with incremental counters only (no multiplier or divider in the datapath).
REQ-009 SHALL, on the write with k=N_CBPS-1, set full[WrBank], toggle WrBank, reset k to 0 and increment the written-symbol count.
REQ-010 SHALL drive read outputs as follows:
- RdEn = full[RdBank] & RdReady.
- RdAddr counts 0..N_CBPS-1, using the rate latched for RdBank.
- RdLast = RdEn at RdAddr=N_CBPS-1; on that cycle clear full[RdBank], toggle RdBank and increment the read-symbol count.
REQ-011 SHALL allow a set of full on one bank and a clear on the other in the same cycle, with both taking effect; write and read SHALL proceed concurrently (ping-pong).
REQ-012 SHALL apply these state transitions:
- IDLE->RUN on Start with NumSymbols>0; clear counters, WrBank=RdBank=0.
- RUN->DRAIN after the last symbol's final write.
- DRAIN->IDLE on RdLast of symbol NumSymbols; Done=1 in that same transition cycle.
REQ-013 SHALL, on Start with NumSymbols=0 in IDLE, pulse Done the following cycle and remain in IDLE.
REQ-014 SHALL ignore Start while Busy=1; Busy=1 iff state is RUN or DRAIN.
REQ-015 SHALL latch NumSymbols at Start.
REQ-016 SHALL use 12-bit symbol counters compared for equality (no wrap).

Reset
REQ-017 SHALL, on Reset=1, asynchronously force:
- state=IDLE, all counters 0, full[1:0]=0.
- WrBank=RdBank=0, per-bank rates=0.
- InReady=WrEn=RdEn=RdLast=Busy=Done=0, WrAddr=RdAddr=0.
REQ-018 SHALL, on Reset asserted mid-frame, abandon the frame without pulsing Done; after Reset is released, the block waits in IDLE for a new Start.

Verification
REQ-019 Rate=0, NumSymbols=1, InValid and RdReady held 1 -> WrAddr sequence 0,3,6,...,45,1,4,...,47; then 48 reads RdAddr 0..47; RdLast on the 48th read; Done one cycle later.
REQ-020 Rate=2 -> WrAddr for k=0,1,2,16 is 0,13,24,1; Rate=3 -> WrAddr for k=0,1,2 is 0,20,37.
REQ-021 NumSymbols=3, RdReady=0 -> InReady drops after 96 writes (both banks full); raising RdReady resumes writes only after the first RdLast.
REQ-022 Rate changed from 0 to 1 at k=20 of symbol 0 -> symbol 0 keeps 48 addresses; symbol 1 uses N_CBPS=96 for both its writes and its reads.
REQ-023 Reset pulsed at k=30 of symbol 1 -> all outputs at reset values, no Done; a new Start with NumSymbols=1 completes normally.
REQ-024 Start with NumSymbols=0 -> Busy stays 0, Done pulses once the following cycle; Start while Busy=1 -> no effect on counters.
